// File: rtl/tqvp_raster_copper.sv
// tqvp_raster_copper: raster-synchronised colour-register sequencer; optional irq latch via COPPER_IRQ_EN
module tqvp_raster_copper #(
  parameter int ENTRIES = 8,
  parameter int Y_W = 10,
  localparam int PC_W = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  input  logic            frame_start,
  input  logic [Y_W-1:0]  vga_y,
  output logic [5:0]      color_out,
  output logic            bg_we,
  output logic            fg_we,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            irq
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic en_q, en_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [5:0] col_q, col_d;
  logic bg_q, bg_d, fg_q, fg_d;
  logic [17:0] ent_q [ENTRIES];
  logic [17:0] ent_d [ENTRIES];
  logic [17:0] cur;
  logic wr_ctl, wr_ent, done_set;
  logic unused_cfg;
  assign unused_cfg = ^cfg_wdata[31:18];
  assign cur = ent_q[pc_q];
  assign wr_ctl = cfg_we && cfg_addr == 4'hF;
  assign wr_ent = cfg_we && 32'(cfg_addr) < ENTRIES;
  // next-state: disable write beats frame_start, which beats the running evaluation
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    col_d = col_q;
    bg_d = 1'b0;
    fg_d = 1'b0;
    done_set = 1'b0;
    en_d = wr_ctl ? cfg_wdata[0] : en_q;
    if (wr_ctl && !cfg_wdata[0]) begin
      state_d = IDLE;
    end else if (frame_start && en_q) begin
      state_d = RUN;
      pc_d = '0;
    end else if (state_q == RUN) begin
      if (cur[17]) begin
        state_d = DONE;
        done_set = 1'b1;
      end else if (vga_y >= cur[Y_W-1:0]) begin
        col_d = cur[15:10];
        bg_d = !cur[16];
        fg_d = cur[16];
        if (pc_q == PC_W'(ENTRIES - 1)) begin
          state_d = DONE;
          done_set = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end
  end
  // command list update; the evaluation above always sees the pre-write entry
  always_comb begin
    ent_d = ent_q;
    if (wr_ent) ent_d[cfg_addr[PC_W-1:0]] = cfg_wdata[17:0];
  end
  // state, list and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      pc_q <= '0;
      col_q <= '0;
      bg_q <= 1'b0;
      fg_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= 18'h2_0000;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      pc_q <= pc_d;
      col_q <= col_d;
      bg_q <= bg_d;
      fg_q <= fg_d;
      ent_q <= ent_d;
    end
  end
`ifdef COPPER_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = done_set | (irq_q & ~(wr_ctl & cfg_wdata[1]));
  // end-of-list latch: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = done_set;
  assign irq = 1'b0;
`endif
  assign color_out = col_q;
  assign bg_we = bg_q;
  assign fg_we = fg_q;
  assign pc = pc_q;
  assign running = state_q == RUN;
endmodule

// File: tb/tb_tqvp_raster_copper.sv
// tb_tqvp_raster_copper: directed and random stimulus against a cycle-level behavioural model
module tb_tqvp_raster_copper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic frame_start = 1'b0;
  logic [9:0] vga_y = '0;
  logic [5:0] color_out;
  logic bg_we, fg_we, running, irq;
  logic [2:0] pc;
  int vectors = 0;
  int miscompares = 0;
  int bg_cnt = 0;
  int fg_cnt = 0;
`ifdef COPPER_IRQ_EN
  localparam int IRQV = 1;
`else
  localparam int IRQV = 0;
`endif
  localparam int END_BIT = 32'h2_0000;
  int m_ent [8];
  int m_en, m_mode, m_pc, m_col, m_bg, m_fg, m_irq;
  always #5 clk = ~clk;
  tqvp_raster_copper dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .frame_start(frame_start), .vga_y(vga_y), .color_out(color_out), .bg_we(bg_we),
    .fg_we(fg_we), .pc(pc), .running(running), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // mode: 0 idle, 1 run, 2 done; one call per clock edge using the inputs presented to it
  task automatic model_step();
    int e, oen;
    bit set;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_ent[i] = END_BIT;
      m_en = 0; m_mode = 0; m_pc = 0; m_col = 0; m_bg = 0; m_fg = 0; m_irq = 0;
      return;
    end
    e = m_ent[m_pc];
    oen = m_en;
    set = 0;
    m_bg = 0;
    m_fg = 0;
    if (cfg_we && cfg_addr == 15) begin
      m_en = int'(cfg_wdata[0]);
      if (IRQV == 1 && cfg_wdata[1]) m_irq = 0;
    end
    if (cfg_we && cfg_addr == 15 && !cfg_wdata[0]) m_mode = 0;
    else if (frame_start && oen == 1) begin
      m_mode = 1;
      m_pc = 0;
    end else if (m_mode == 1) begin
      if ((e & END_BIT) != 0) begin
        m_mode = 2;
        set = 1;
      end else if (int'(vga_y) >= (e & 1023)) begin
        m_col = (e >> 10) & 63;
        m_fg = (e >> 16) & 1;
        m_bg = 1 - m_fg;
        if (m_pc == 7) begin
          m_mode = 2;
          set = 1;
        end else m_pc++;
      end
    end
    if (set && IRQV == 1) m_irq = 1;
    if (cfg_we && cfg_addr < 8) m_ent[cfg_addr] = int'(cfg_wdata & 32'h3FFFF);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("bg_we", 32'(bg_we), 32'(m_bg));
    chk("fg_we", 32'(fg_we), 32'(m_fg));
    chk("color_out", 32'(color_out), 32'(m_col));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("exclusive", 32'(bg_we & fg_we), 0);
    if (bg_we) bg_cnt++;
    if (fg_we) fg_cnt++;
    cfg_we = 1'b0;
    frame_start = 1'b0;
  endtask
  task automatic wr(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_wdata = 32'(d);
    cyc();
  endtask
  task automatic fs();
    frame_start = 1'b1;
    cyc();
  endtask
  initial begin
    int r;
    logic [31:0] d;
    cyc();
    cyc();
    chk("rst_running", 32'(running), 0);
    chk("rst_color", 32'(color_out), 0);
    rst_n = 1'b1;
    // empty list: straight to DONE without strobes
    wr(15, 1);
    fs();
    chk("t1_run", 32'(running), 1);
    cyc();
    chk("t1_done", 32'(running), 0);
    chk("t1_pc", 32'(pc), 0);
    chk("t1_irq", 32'(irq), IRQV);
    // single background change at scanline 100
    wr(0, 100 | (6'h30 << 10));
    wr(1, END_BIT);
    wr(15, 3);
    vga_y = 0;
    bg_cnt = 0;
    fs();
    for (int y = 0; y <= 200; y++) begin
      vga_y = 10'(y);
      cyc();
      if (y == 100) begin
        chk("t2_strobe", 32'(bg_we), 1);
        chk("t2_color", 32'(color_out), 32'h30);
      end
    end
    chk("t2_count", 32'(bg_cnt), 1);
    chk("t2_done", 32'(running), 0);
    // three already-passed entries fire back to back
    wr(0, (1 << 16) | (1 << 10));
    wr(1, 2 << 10);
    wr(2, (1 << 16) | (3 << 10));
    wr(3, END_BIT);
    fs();
    cyc();
    chk("t3_fg1", 32'({fg_we, color_out}), 32'h41);
    cyc();
    chk("t3_bg2", 32'({bg_we, color_out}), 32'h42);
    cyc();
    chk("t3_fg3", 32'({fg_we, color_out}), 32'h43);
    cyc();
    cyc();
    // full list without END, replayed twice
    for (int i = 0; i < 8; i++) wr(i, (i << 10) | ((i & 1) << 16));
    for (int k = 0; k < 2; k++) begin
      bg_cnt = 0;
      fg_cnt = 0;
      fs();
      for (int i = 0; i < 10; i++) cyc();
      chk("t4_count", 32'(bg_cnt + fg_cnt), 8);
      chk("t4_pc", 32'(pc), 7);
      chk("t4_done", 32'(running), 0);
    end
    // disable while waiting
    wr(0, 300);
    wr(1, END_BIT);
    vga_y = 0;
    fs();
    vga_y = 150;
    cyc();
    cyc();
    wr(15, 0);
    chk("t5_idle", 32'(running), 0);
    bg_cnt = 0;
    for (int y = 150; y <= 310; y++) begin
      vga_y = 10'(y);
      cyc();
    end
    chk("t5_nostrobe", 32'(bg_cnt), 0);
    fs();
    chk("t5_stay_idle", 32'(running), 0);
    // rewrite the entry being evaluated
    wr(15, 1);
    wr(0, 500);
    vga_y = 20;
    fs();
    cyc();
    wr(0, 10);
    chk("t6_write_cycle", 32'(bg_we), 0);
    cyc();
    chk("t6_fire", 32'(bg_we), 1);
    // reset in the middle of a run
    wr(0, 500);
    fs();
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("t7_running", 32'(running), 0);
    chk("t7_pc", 32'(pc), 0);
    rst_n = 1'b1;
    wr(15, 1);
    bg_cnt = 0;
    fg_cnt = 0;
    fs();
    cyc();
    chk("t7_end_restored", 32'(running), 0);
    chk("t7_no_strobe", 32'(bg_cnt + fg_cnt), 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 40) frame_start = 1'b1;
      if (r >= 100 && r < 250) begin
        d = $urandom;
        d[17] = ($urandom_range(0, 3) == 0);
        cfg_addr = 4'($urandom_range(0, 9));
        if (cfg_addr == 4'd8) cfg_addr = 4'hF;
        if (cfg_addr == 4'hF) d[0] = ($urandom_range(0, 9) != 0);
        cfg_we = 1'b1;
        cfg_wdata = d;
      end
      rst_n = (r != 999);
      vga_y = ($urandom_range(0, 19) == 0) ? 10'($urandom) : vga_y + 10'd1;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
